// File: rtl/rotation_pkg.sv
// Shared types and helpers for the rotating-square tick controller.
package rotation_pkg;
  localparam int SPEED_W = 2;

  typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} db_state_t;

  function automatic int unsigned tick_period(input int unsigned base, input logic [SPEED_W-1:0] speed);
    return base >> speed;
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus a stability-counting debouncer; one press pulse per accepted rising level.
module btn_debounce
  import rotation_pkg::*;
#(
  parameter int DB_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync;
  logic          din;
  db_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  assign din = sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      state <= ZERO;
      cnt   <= '0;
    end else begin
      sync  <= {sync[0], btn};
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press     = 1'b0;
    case (state)
      ZERO: if (din) begin
        state_nxt = WAIT1;
        cnt_nxt   = '0;
      end
      WAIT1: begin
        if (!din) state_nxt = ZERO;
        else if (cnt == CNT_LAST) begin
          state_nxt = ONE;
          press     = 1'b1;
        end else cnt_nxt = cnt + 1'b1;
      end
      ONE: if (!din) begin
        state_nxt = WAIT0;
        cnt_nxt   = '0;
      end
      WAIT0: begin
        if (din) state_nxt = ONE;
        else if (cnt == CNT_LAST) state_nxt = ZERO;
        else cnt_nxt = cnt + 1'b1;
      end
      default: state_nxt = ZERO;
    endcase
  end

  assign level = (state == ONE) || (state == WAIT0);
endmodule

// File: rtl/rotation_tick_ctrl.sv
// Run/pause and single-step control producing the enable strobe for the rotating-square counter.
module rotation_tick_ctrl
  import rotation_pkg::*;
#(
  parameter int   BASE_DIV     = 1_000_000,
  parameter int   DB_CYCLES    = 2_000_000,
  parameter logic RUN_AT_RESET = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_run,
  input  logic               btn_step,
  input  logic [SPEED_W-1:0] speed,
  output logic               enable,
  output logic               running
);
  localparam int NUM_BTN = 2;
  localparam int PW      = $clog2(BASE_DIV);

  logic [NUM_BTN-1:0] btn_raw, lvl, prs, evt;
  logic               run_press, step_press;

  assign btn_raw = {btn_step, btn_run};

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db [NUM_BTN-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_raw),
    .level (lvl),
    .press (prs)
  );

  // A press only ever fires from the released side of the debouncer.
  assign evt        = prs & ~lvl;
  assign run_press  = evt[0];
  assign step_press = evt[1];

  logic [SPEED_W-1:0] speed_q;
  logic [PW-1:0]      pcnt, per_last;
  logic               spd_chg, at_last, restart, tick, step_fire;

  assign per_last  = PW'(tick_period(BASE_DIV, speed_q) - 1);
  assign spd_chg   = (speed != speed_q);
  assign at_last   = (pcnt == per_last);
  assign restart   = !running || run_press || spd_chg;
  assign tick      = running && !run_press && !spd_chg && at_last;
  // A run toggle in the same cycle wins over a step.
  assign step_fire = !running && step_press && !run_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed_q <= '0;
      pcnt    <= '0;
      enable  <= 1'b0;
      running <= RUN_AT_RESET;
    end else begin
      speed_q <= speed;
      pcnt    <= (restart || at_last) ? '0 : pcnt + 1'b1;
      // Guard keeps the strobe single-cycle even at a period of one.
      enable  <= (tick || step_fire) && !enable;
      running <= running ^ run_press;
    end
  end
endmodule

// File: tb/tb_rotation_tick_ctrl.sv
// Self-checking bench: vector table, directed corner sequences, random stimulus against a reference model.
module tb_rotation_tick_ctrl;
  localparam int BASE_DIV = 16;
  localparam int DB       = 4;

  logic       clk = 1'b0, rst_n = 1'b0, btn_run = 1'b0, btn_step = 1'b0;
  logic [1:0] speed = 2'd0;
  logic       enable, running;

  rotation_tick_ctrl #(.BASE_DIV(BASE_DIV), .DB_CYCLES(DB), .RUN_AT_RESET(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .btn_run(btn_run), .btn_step(btn_step),
    .speed(speed), .enable(enable), .running(running)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: buttons accepted after DB+1 stable synced cycles, ticks every P running cycles.
  bit m_s0[2], m_s1[2], m_acc[2];
  int m_runlen[2];
  bit m_running, m_en;
  int m_spdq, m_el, m_pulses;
  int pulses;
  bit prev_en;

  function automatic void model_reset();
    for (int b = 0; b < 2; b++) begin
      m_s0[b] = 0; m_s1[b] = 0; m_acc[b] = 0; m_runlen[b] = 0;
    end
    m_running = 0; m_en = 0; m_spdq = 0; m_el = 0;
  endfunction

  task automatic cyc();
    bit raw[2];
    bit prs[2];
    int r, p;
    bit fire, chg, tick, stp;
    raw[0] = btn_run;
    raw[1] = btn_step;
    for (int b = 0; b < 2; b++) begin
      r = (m_s1[b] != m_acc[b]) ? m_runlen[b] + 1 : 0;
      fire = (r == DB + 1);
      prs[b] = fire && m_s1[b];
      m_runlen[b] = fire ? 0 : r;
      if (fire) m_acc[b] = m_s1[b];
      m_s1[b] = m_s0[b];
      m_s0[b] = raw[b];
    end
    p    = BASE_DIV >> m_spdq;
    chg  = (int'(speed) != m_spdq);
    tick = m_running && !prs[0] && !chg && ((m_el % p) == p - 1);
    stp  = !m_running && prs[1] && !prs[0];
    m_el = (!m_running || prs[0] || chg) ? 0 : m_el + 1;
    m_running = m_running ^ prs[0];
    m_en   = (tick || stp) && !m_en;
    m_spdq = int'(speed);
    @(posedge clk);
    #1;
    chk("enable", int'(enable), int'(m_en));
    chk("running", int'(running), int'(m_running));
    chk("no_consec", int'(enable && prev_en), 0);
    if (enable) pulses++;
    if (m_en) m_pulses++;
    prev_en = enable;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_enable", int'(enable), 0);
    chk("reset_running", int'(running), 0);
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    prev_en = 0;
    rst_n = 1'b1;
  endtask

  task automatic wait_en(input int budget, output int n);
    n = 0;
    for (int k = 0; k < budget; k++) begin
      cyc();
      n++;
      if (enable) return;
    end
    n = -1;
  endtask

  task automatic wait_run(input bit lvl, input int budget, output int n);
    n = 0;
    for (int k = 0; k < budget; k++) begin
      cyc();
      n++;
      if (running == lvl) return;
    end
    n = -1;
  endtask

  task automatic hold(input bit r, input bit s, input int n);
    btn_run = r;
    btn_step = s;
    repeat (n) cyc();
  endtask

  typedef struct {
    bit run;
    bit step;
    int spd;
    int ncyc;
    bit exp_running;
    int exp_pulses;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hr, hs;
    tbl[0] = '{0, 0, 0, 100, 0, 0};
    tbl[1] = '{1, 0, 0, 10,  1, 0};
    tbl[2] = '{0, 0, 0, 30,  1, 2};
    tbl[3] = '{0, 0, 0, 16,  1, 1};
    tbl[4] = '{0, 1, 0, 10,  1, 0};
    tbl[5] = '{0, 0, 0, 10,  1, 1};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      btn_run  = tbl[i].run;
      btn_step = tbl[i].step;
      speed    = 2'(tbl[i].spd);
      pulses   = 0;
      repeat (tbl[i].ncyc) cyc();
      chk($sformatf("tbl%0d_running", i), int'(running), int'(tbl[i].exp_running));
      chk($sformatf("tbl%0d_pulses", i), pulses, tbl[i].exp_pulses);
    end

    // Press latency and the first two periods at speed 0.
    do_reset();
    btn_run = 1'b1;
    wait_run(1'b1, 20, n);
    chk("run_latency", n, 7);
    wait_en(40, n);
    chk("first_period", n, 16);
    btn_run = 1'b0;
    wait_en(40, n);
    chk("second_period", n, 16);

    // Speed change mid-period restarts the prescaler.
    repeat (5) cyc();
    speed = 2'd2;
    wait_en(40, n);
    chk("spd_first", n, 5);
    for (int k = 0; k < 3; k++) begin
      wait_en(40, n);
      chk($sformatf("spd_period%0d", k), n, 4);
    end

    // Short bounce is rejected.
    hold(1, 0, 1); hold(0, 0, 1); hold(1, 0, 1); hold(0, 0, 20);
    chk("bounce_running", int'(running), 1);

    // Pause, then three clean steps.
    hold(1, 0, 10); hold(0, 0, 10);
    chk("pause_running", int'(running), 0);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      hold(0, 1, 8); hold(0, 0, 8);
    end
    chk("step_pulses", pulses, 3);

    // Steps while running add nothing beyond the periodic ticks.
    hold(1, 0, 10); hold(0, 0, 10);
    chk("resume_running", int'(running), 1);
    pulses = 0; m_pulses = 0;
    for (int k = 0; k < 3; k++) begin
      hold(0, 1, 8); hold(0, 0, 8);
    end
    chk("run_step_pulses", pulses, m_pulses);

    // Reset at prescaler count 10.
    speed = 2'd0;
    wait_en(60, n);
    repeat (10) cyc();
    do_reset();
    pulses = 0;
    hold(0, 0, 30);
    chk("post_reset_idle", pulses, 0);
    btn_run = 1'b1;
    wait_run(1'b1, 20, n);
    chk("post_reset_latency", n, 7);
    btn_run = 1'b0;
    wait_en(40, n);
    chk("post_reset_period", n, 16);

    // Reset while the run debouncer sits in WAIT1.
    hold(0, 0, 10);
    btn_run = 1'b1;
    repeat (3) cyc();
    do_reset();
    wait_run(1'b1, 20, n);
    chk("wait1_reset_latency", n, 7);
    hold(0, 0, 10);

    // Random stimulus against the model.
    hr = 0; hs = 0;
    for (int k = 0; k < 4000; k++) begin
      if (hr == 0) begin
        btn_run = 1'($urandom_range(0, 1));
        hr = $urandom_range(1, 14);
      end
      if (hs == 0) begin
        btn_step = 1'($urandom_range(0, 1));
        hs = $urandom_range(1, 14);
      end
      if ($urandom_range(0, 63) == 0) speed = 2'($urandom_range(0, 3));
      hr--; hs--;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
